// File: rtl/hyper_pipe_sink_fifo_pkg.sv
// Package shared by the hyper-pipe sink FIFO slice.
//  - Default configuration constants (data/empty width, depth, pipe count).
//  - sink_entry_t: one buffered beat {sop, eop, empty, data} at the default widths.
//  - occ_width(): width of an occupancy counter able to hold 0..depth.
//  - frame_state_t: framing checker states.
package hyper_pipe_sink_fifo_pkg;

  localparam int SINK_DATA_W    = 512;
  localparam int SINK_EMPTY_W   = 6;
  localparam int SINK_DEPTH     = 32;
  localparam int SINK_NUM_PIPES = 1;

  typedef struct packed {
    logic                    sop;
    logic                    eop;
    logic [SINK_EMPTY_W-1:0] empty;
    logic [SINK_DATA_W-1:0]  data;
  } sink_entry_t;

  // One extra bit so that a completely full buffer (== depth) is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int SINK_OCC_W = occ_width(SINK_DEPTH);

  typedef enum logic {
    FR_IDLE   = 1'b0,
    FR_IN_PKT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/hyper_pipe_sink_fifo_ram.sv
// sink_fifo_ram: DEPTH x WIDTH storage for the sink FIFO.
//  One synchronous write port and one combinational read port so the head
//  entry is always visible (show-ahead). Contents are never reset.
// Ports:
//  clk      in  clock
//  wr_en    in  write strobe
//  wr_addr  in  write address
//  wr_data  in  write data
//  rd_addr  in  read address (head pointer)
//  rd_data  out entry at rd_addr
module sink_fifo_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 520,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/hyper_pipe_sink_fifo.sv
// hyper_pipe_sink_fifo: receive end of a hyper-piped packet stream.
//  Buffers every in-flight beat, presents it as valid/ready with one cycle of
//  latency, raises in_almost_full early enough to absorb the pipe round trip,
//  flags overflow (sticky) and packet framing violations (sticky).
// Ports:
//  clk, rst_n                      clock, async active-low reset
//  in_sop/eop/data/empty/valid     incoming beat (no ready)
//  in_almost_full                  registered stop request to the source
//  out_sop/eop/data/empty/valid    head beat, out_ready accepts it
//  occupancy                       current entry count
//  overflow                        sticky: beat dropped because full
//  framing_err                     sticky: sop/eop protocol violation
module hyper_pipe_sink_fifo
  import hyper_pipe_sink_fifo_pkg::*;
#(
  parameter int DATA_W    = SINK_DATA_W,
  parameter int EMPTY_W   = SINK_EMPTY_W,
  parameter int DEPTH     = SINK_DEPTH,
  parameter int NUM_PIPES = SINK_NUM_PIPES,
  localparam int OCC_W    = occ_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               in_valid,
  output logic               in_almost_full,
  output logic               out_sop,
  output logic               out_eop,
  output logic [DATA_W-1:0]  out_data,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OCC_W-1:0]   occupancy,
  output logic               overflow,
  output logic               framing_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = DATA_W + EMPTY_W + 2;
  // af pipe + data pipe + af register + source reaction
  localparam int SLACK   = 2 * NUM_PIPES + 2;

  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] AF_LVL   = OCC_W'(DEPTH - SLACK);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  frame_state_t     state_q, state_d;

  logic               push, pop, full;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign full      = (occ_q == FULL_LVL);
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  // When full, a simultaneous pop frees the slot being written this cycle.
  assign push      = in_valid && (!full || pop);

  assign wr_entry = {in_sop, in_eop, in_empty, in_data};

  sink_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  assign {out_sop, out_eop, out_empty, out_data} = rd_entry;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    af_d  = (occ_d >= AF_LVL);
    ovf_d = ovf_q | (in_valid && full && !pop);
  end

  // Framing checker sees every valid beat, including ones dropped on overflow.
  always_comb begin
    state_d = state_q;
    ferr_d  = ferr_q;
    if (in_valid) begin
      case (state_q)
        FR_IDLE: begin
          if (in_sop) begin
            state_d = in_eop ? FR_IDLE : FR_IN_PKT;
          end else begin
            ferr_d = 1'b1;
          end
        end
        FR_IN_PKT: begin
          if (in_sop) begin
            // Missing eop: restart as a new packet.
            ferr_d  = 1'b1;
            state_d = in_eop ? FR_IDLE : FR_IN_PKT;
          end else if (in_eop) begin
            state_d = FR_IDLE;
          end
        end
        default: state_d = FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      state_q  <= FR_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      state_q  <= state_d;
    end
  end

  assign in_almost_full = af_q;
  assign occupancy      = occ_q;
  assign overflow       = ovf_q;
  assign framing_err    = ferr_q;

endmodule
